// File: rtl/mul_ctrl.sv
// -----------------------------------------------------------------------------
// mul_ctrl
//   Arbitration and sequencing wrapper around a 4x4 multi-cycle multiplier.
//   Two requesters share one multiplier. Arbitration is round-robin. The
//   winner's operands are captured and held for the three edges the
//   multiplier needs. The 8-bit product is returned with a one-cycle done
//   pulse to the requester that owns the operation.
//
//   The multiplier datapath (stages p0 -> p1 -> p) is kept in this file. It
//   has no valid or hold logic and no reset, as the original multiplier does.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   req0/req1      level requests
//   a0,b0 / a1,b1  4-bit operands, sampled on the grant edge
//   gnt0/gnt1      one-cycle grant pulse (registered)
//   done0/done1    one-cycle result-valid pulse (registered)
//   p_out          product of the last completed operation, held between completions
//   busy           high whenever the controller is not idle
// -----------------------------------------------------------------------------
module mul_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] p_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAP  = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_owner;
  logic       r_last;
  logic [1:0] r_cnt;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_done0;
  logic       r_done1;
  logic [7:0] r_p_out;

  // Multiplier pipeline registers
  logic [7:0] r_p0;
  logic [7:0] r_p1;
  logic [7:0] r_p;

  logic       w_any_req;
  logic       w_win;
  logic [7:0] w_pp_lo;
  logic [7:0] w_pp_hi;

  // On a tie the requester that did not win last time goes first.
  assign w_any_req = req0 | req1;
  assign w_win     = (req0 & req1) ? ~r_last : req1;

  // Partial products: low operand bits b[1:0], then high bits b[3:2] weighted by 4.
  assign w_pp_lo = {4'b0000, r_a} * {6'b000000, r_b[1:0]};
  assign w_pp_hi = ({4'b0000, r_a} * {6'b000000, r_b[3:2]}) << 2;

  // NOTE: these datapath registers are deliberately left without a reset. The
  // three edges during which r_a/r_b are held rewrite all of them before r_p is
  // read in CAP, so stale contents never reach p_out.
  always_ff @(posedge clk) begin
    r_p0 <= w_pp_lo;
    r_p1 <= r_p0 + w_pp_hi;
    r_p  <= r_p1;
  end

  // NOTE: all state uses non-blocking assignments. Every register then updates
  // from values sampled at the same edge, whatever the order of the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 2'd0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_p_out <= 8'h00;
    end else begin
      // NOTE: the pulses default low on every edge. A state only raises the
      // pulse it needs, so every pulse lasts exactly one cycle.
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_a     <= w_win ? a1 : a0;
            r_b     <= w_win ? b1 : b0;
            r_owner <= w_win;
            r_last  <= w_win;
            r_cnt   <= 2'd0;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // r_a/r_b are held here while the multiplier stages fill.
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd2) begin
            r_state <= S_CAP;
          end
        end
        S_CAP: begin
          r_p_out <= r_p;
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign p_out = r_p_out;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_ctrl
//   Scoreboard bench for mul_ctrl. A transaction-level model decides which
//   requester wins each arbitration and on which edge. Each predicted
//   operation (owner, product, done edge) goes into a queue. A separate
//   monitor pops the queue whenever done is seen.
// -----------------------------------------------------------------------------
module tb_mul_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [3:0] a0 = 4'd0;
  logic [3:0] b0 = 4'd0;
  logic [3:0] a1 = 4'd0;
  logic [3:0] b1 = 4'd0;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [7:0] p_out;
  logic       busy;

  mul_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .p_out (p_out),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } op_t;

  typedef struct {
    int owner;
    int prod;
    int edge_n;
  } exp_t;

  op_t  pend0[$];
  op_t  pend1[$];
  exp_t sb[$];

  int cyc      = 0;   // number of rising edges so far
  int m_free   = 0;   // first edge at which the model accepts a new grant
  int m_last   = 1;   // model's last granted requester
  int last_p   = 0;   // model's p_out
  int checks   = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero();
    check("rst_gnt0", {31'd0, gnt0}, 0);
    check("rst_gnt1", {31'd0, gnt1}, 0);
    check("rst_done0", {31'd0, done0}, 0);
    check("rst_done1", {31'd0, done1}, 0);
    check("rst_p_out", {24'd0, p_out}, 0);
    check("rst_busy", {31'd0, busy}, 0);
  endtask

  // Requester driver and arbitration model. At the falling edge after rising
  // edge k, the req/operand values still on the pins are the ones edge k sampled.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end else begin
        int w;
        w = -1;
        if (cyc >= m_free && (req0 || req1)) begin
          int prod;
          if (req0 && req1) w = (m_last == 0) ? 1 : 0;
          else              w = req1 ? 1 : 0;
          prod = (w == 1) ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
          sb.push_back('{w, prod, cyc + 4});
          m_last = w;
          m_free = cyc + 5;
          if (w == 1) void'(pend1.pop_front());
          else        void'(pend0.pop_front());
        end
        check("gnt0", {31'd0, gnt0}, (w == 0) ? 1 : 0);
        check("gnt1", {31'd0, gnt1}, (w == 1) ? 1 : 0);
        check("busy", {31'd0, busy}, (cyc + 2 <= m_free) ? 1 : 0);
        // Drive the next request. Operands of an idle requester change randomly.
        req0 = (pend0.size() > 0);
        if (req0) begin a0 = pend0[0].a; b0 = pend0[0].b; end
        else begin a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15)); end
        req1 = (pend1.size() > 0);
        if (req1) begin a1 = pend1[0].a; b1 = pend1[0].b; end
        else begin a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15)); end
      end
    end
  end

  // Completion monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done0 || done1) begin
          if (sb.size() == 0) begin
            check("done_unexpected", {30'd0, done1, done0}, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_owner", {30'd0, done1, done0}, (e.owner == 1) ? 2 : 1);
            check("done_edge", cyc, e.edge_n);
            last_p = e.prod;
          end
        end else if (sb.size() > 0 && cyc > sb[0].edge_n) begin
          check("done_timeout", cyc, sb[0].edge_n);
          void'(sb.pop_front());
        end
        check("p_out", {24'd0, p_out}, last_p);
      end
    end
  end

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_zero();
    pend0.delete();
    pend1.delete();
    sb.delete();
    m_last = 1;
    m_free = 0;
    last_p = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (pend0.size() == 0 && pend1.size() == 0 && sb.size() == 0 && cyc >= m_free) return;
    end
    check("idle_timeout", sb.size() + pend0.size() + pend1.size(), 0);
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.a = 4'($urandom_range(0, 15));
    o.b = 4'($urandom_range(0, 15));
    return o;
  endfunction

  initial begin
    // Power-on reset
    @(negedge clk);
    #1 check_zero();
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single request: 13*11
    pend0.push_back('{4'd13, 4'd11});
    wait_idle();
    check("single_p", {24'd0, p_out}, 143);

    // Tie after reset: requester 0 first, then requester 1
    do_reset();
    pend0.push_back('{4'd15, 4'd15});
    pend1.push_back('{4'd3, 4'd5});
    wait_idle();
    check("tie_p", {24'd0, p_out}, 15);

    // Round-robin with both requests held for four operations
    for (int i = 0; i < 2; i++) begin
      pend0.push_back(rand_op());
      pend1.push_back(rand_op());
    end
    wait_idle();

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1 && pend0.size() < 2) pend0.push_back(rand_op());
      if ($urandom_range(0, 1) == 1 && pend1.size() < 2) pend1.push_back(rand_op());
      repeat ($urandom_range(0, 8)) @(negedge clk);
      #1;
    end
    wait_idle();

    // Reset in RUN with cnt=1, then a fresh request from requester 1
    pend0.push_back(rand_op());
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) break;
    end
    check("midrun_granted", sb.size(), 1);
    @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    #1;
    pend1.push_back('{4'd7, 4'd9});
    wait_idle();
    check("rst_p", {24'd0, p_out}, 63);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
